frag_writer: RTL

FRAG_WRITER -- requirements
Module: frag_writer

---
 rtl/frag_writer_pkg.sv | 17 +
 rtl/fp16_to_pix.sv | 22 ++
 rtl/frag_writer.sv | 101 ++++++++++
 3 files changed

// File: rtl/frag_writer_pkg.sv
// frag_writer_pkg: shared pixel pipeline constants, half-float layout and write FSM encoding
package frag_writer_pkg;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int FP_W = 16;
  localparam int FP_EXP_W = 5;
  localparam int FP_MANT_W = 10;
  localparam int FP_BIAS = 15;
  localparam int PIX_W = 16;
  localparam int ADDR_W = 19;
  localparam int COLOR_W = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} wr_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } frag_t;
endpackage

// File: rtl/fp16_to_pix.sv
// fp16_to_pix: maps a normalized half-float coordinate in [0,1) onto a pixel index in [0,RES)
module fp16_to_pix
  import frag_writer_pkg::*;
#(
  parameter int RES = H_RES_DEF
) (
  input  logic [FP_W-1:0]  fp,
  output logic [PIX_W-1:0] pix
);
  logic [FP_EXP_W-1:0] e;
  logic [31:0] prod;
  logic [31:0] scaled;
  // Scale the significand by RES and undo the exponent; negatives and zero/denormals pin to 0, >=1.0 pins to the last pixel
  always_comb begin
    e = fp[FP_W-2 -: FP_EXP_W];
    prod = ((32'(1) << FP_MANT_W) | 32'(fp[FP_MANT_W-1:0])) * 32'(RES);
    scaled = prod >> (FP_BIAS + FP_MANT_W - int'(e));
    pix = (fp[FP_W-1] || e == '0) ? '0
        : (int'(e) >= FP_BIAS || scaled >= 32'(RES)) ? PIX_W'(RES - 1)
        : PIX_W'(scaled);
  end
endmodule

// File: rtl/frag_writer.sv
// frag_writer: converts fragments to framebuffer addresses, buffers them and issues acknowledged writes
module frag_writer
  import frag_writer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frag_rdy,
  input  logic [FP_W-1:0]    fp_x,
  input  logic [FP_W-1:0]    fp_y,
  input  logic [COLOR_W-1:0] frag_color,
  output logic               ds_rfd,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ack,
  input  logic               clr_count,
  output logic [ADDR_W-1:0]  frag_count,
  output logic               busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [PIX_W-1:0] x_pix;
  logic [PIX_W-1:0] y_pix;
  logic             accept;
  logic             s1_valid;
  frag_t            s1;
  frag_t            mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      fifo_count;
  wr_state_e        state;
  logic             pop;
  logic             more;
  frag_t            nxt;

  fp16_to_pix #(.RES(H_RES)) u_x (.fp(fp_x), .pix(x_pix));
  fp16_to_pix #(.RES(V_RES)) u_y (.fp(fp_y), .pix(y_pix));

  // Counting the stage-1 slot against free space guarantees every accepted fragment has a FIFO entry
  assign ds_rfd = rst_n && (int'(fifo_count) + int'(s1_valid)) < FIFO_DEPTH;
  assign busy = rst_n && (s1_valid || fifo_count != '0 || state == ST_WRITE);
  assign accept = frag_rdy && ds_rfd;
  assign pop = state == ST_WRITE && fb_ack;
  // The head stays in the FIFO while being written, so a follow-on entry is either behind it or arriving from stage 1
  assign more = fifo_count > (PW+1)'(1) || s1_valid;
  assign nxt = fifo_count > (PW+1)'(1) ? mem[rd_ptr + PW'(1)] : s1;

  // Stage 1: register the converted address and color of an accepted fragment
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else s1_valid <= accept;
    if (accept) s1 <= '{ADDR_W'(32'(y_pix) * 32'(H_RES) + 32'(x_pix)), frag_color};
  end

  // FIFO storage, written whenever stage 1 holds a fragment
  always_ff @(posedge clk) if (s1_valid) mem[wr_ptr] <= s1;

  // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(s1_valid);
      rd_ptr <= rd_ptr + PW'(pop);
      fifo_count <= fifo_count + (PW+1)'(s1_valid) - (PW+1)'(pop);
    end
  end

  // Write FSM: present the head entry and hold it until the framebuffer acknowledges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (state == ST_IDLE) begin
      if (fifo_count != '0) begin
        state <= ST_WRITE;
        fb_we <= 1'b1;
        {fb_addr, fb_data} <= mem[rd_ptr];
      end
    end else if (fb_ack) begin
      if (more) {fb_addr, fb_data} <= nxt;
      else begin
        state <= ST_IDLE;
        fb_we <= 1'b0;
      end
    end
  end

  // Completed-write counter; clear wins over a same-cycle increment and the count wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n || clr_count) frag_count <= '0;
    else if (pop) frag_count <= frag_count + ADDR_W'(1);
  end
endmodule
